// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the data-memory port arbiter
// Contents: arb_state_t (ARB/LOCK), mem_req_t (one requester's access fields),
//           REQ_CORE/REQ_PROG requester indices, REQ_ADDR_W struct address width.
package mem_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Address field is sized for the widest supported AW; the top slices it back down.
    localparam int REQ_ADDR_W = 64;

    typedef struct packed {
        logic                  we;
        logic [3:0]            be;
        logic [REQ_ADDR_W-1:0] addr;
        logic [31:0]           wdata;
    } mem_req_t;

    localparam int REQ_CORE = 0;
    localparam int REQ_PROG = 1;

endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - two-way round-robin pick with a registered priority pointer
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   req_i[1:0]    requests, bit 0 = core, bit 1 = prog
//   en_i          arbitration enabled this cycle (no grant when low)
//   set_core_i    force the pointer to favour the core on the next conflict
//   gnt_o[1:0]    one-hot combinational grant
module arb_rr2 #(
    parameter bit PRIO1_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       en_i,
    input  logic       set_core_i,
    output logic [1:0] gnt_o
);

    // prio_q = 1: requester 1 wins the next conflict; 0: requester 0 wins.
    logic prio_q, prio_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (&req_i) begin
                gnt_o = prio_q ? 2'b10 : 2'b01;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    // Priority flips to the loser of every grant, so a core grant hands priority to prog.
    always_comb begin
        prio_d = prio_q;
        if (set_core_i) begin
            prio_d = 1'b0;
        end else if (|gnt_o) begin
            prio_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= PRIO1_RESET;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one data-memory port between the core and the UART loader
// Optional build macro: ARB_PERF_CNT_EN adds saturating perf counters.
// Ports:
//   clk, Rst                          clock, asynchronous active-high reset
//   core_req/we/be/addr/wdata         core memory-stage request (requester 0)
//   core_gnt/rvalid/rdata             core grant and read return
//   prog_req/we/be/addr/wdata/lock    loader request (requester 1) and burst lock
//   prog_gnt/rvalid/rdata             loader grant and read return
//   mem_en/wea/rea/addr/din, mem_dout memory macro port, 1-cycle read latency
//   mem_hold                          core stall while its request is not granted
//   lock_err                          sticky lock timeout flag, cleared when prog_lock falls
//   perf_core_stall/prog_gnt/core_gnt (ARB_PERF_CNT_EN only) saturating event counters
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int LOCK_MAX    = 256,
    parameter bit PRIO1_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          Rst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [3:0]    core_be,
    input  logic [AW-1:0] core_addr,
    input  logic [31:0]   core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [31:0]   core_rdata,
    input  logic          prog_req,
    input  logic          prog_we,
    input  logic [3:0]    prog_be,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_wdata,
    input  logic          prog_lock,
    output logic          prog_gnt,
    output logic          prog_rvalid,
    output logic [31:0]   prog_rdata,
    output logic [3:0]    mem_en,
    output logic          mem_wea,
    output logic          mem_rea,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_din,
    input  logic [31:0]   mem_dout,
    output logic          mem_hold,
    output logic          lock_err
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]   perf_core_stall,
    output logic [31:0]   perf_prog_gnt,
    output logic [31:0]   perf_core_gnt
`endif
);

    localparam int TW = $clog2(LOCK_MAX);

    arb_state_t    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          lock_err_q, lock_err_d;
    logic          rd_pending_q, rd_pending_d;
    logic          rd_owner_q, rd_owner_d;

    logic [1:0]    rr_gnt;
    logic          rr_en;
    logic          rr_set_core;

    mem_req_t      core_r, prog_r, win_r;
    logic          win_valid;
    logic          unused_addr_bits;

    // Reset also gates the combinational grant path so every output is 0 while Rst is high.
    assign rr_en = ~Rst & (state_q == ARB);

    arb_rr2 #(
        .PRIO1_RESET (PRIO1_RESET)
    ) u_rr (
        .clk        (clk),
        .rst        (Rst),
        .req_i      ({prog_req, core_req}),
        .en_i       (rr_en),
        .set_core_i (rr_set_core),
        .gnt_o      (rr_gnt)
    );

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        lock_err_d  = lock_err_q;
        rr_set_core = 1'b0;
        core_gnt    = 1'b0;
        prog_gnt    = 1'b0;
        if (!prog_lock) begin
            lock_err_d = 1'b0;
        end
        if (!Rst) begin
            unique case (state_q)
                ARB: begin
                    core_gnt = rr_gnt[REQ_CORE];
                    prog_gnt = rr_gnt[REQ_PROG];
                    // A timed-out lock cannot be re-taken until prog_lock is dropped.
                    if (rr_gnt[REQ_PROG] && prog_lock && !lock_err_q) begin
                        state_d = LOCK;
                        timer_d = '0;
                    end
                end
                LOCK: begin
                    prog_gnt = prog_req;
                    timer_d  = timer_q + 1'b1;
                    if (!prog_lock) begin
                        state_d     = ARB;
                        rr_set_core = 1'b1;
                    end else if (timer_q == TW'(LOCK_MAX - 1)) begin
                        state_d     = ARB;
                        rr_set_core = 1'b1;
                        lock_err_d  = 1'b1;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    always_comb begin
        core_r = '{we: core_we, be: core_be, addr: REQ_ADDR_W'(core_addr), wdata: core_wdata};
        prog_r = '{we: prog_we, be: prog_be, addr: REQ_ADDR_W'(prog_addr), wdata: prog_wdata};
        win_r  = '0;
        if (prog_gnt) begin
            win_r = prog_r;
        end else if (core_gnt) begin
            win_r = core_r;
        end
    end

    assign win_valid        = core_gnt | prog_gnt;
    assign unused_addr_bits = ^win_r.addr;

    assign mem_en   = win_r.be;
    assign mem_wea  = win_valid & win_r.we;
    assign mem_rea  = win_valid & ~win_r.we;
    assign mem_addr = win_r.addr[AW-1:0];
    assign mem_din  = win_r.wdata;
    assign mem_hold = core_req & ~core_gnt & ~Rst;
    assign lock_err = lock_err_q;

    // The read owner is only meaningful while rd_pending_q is set.
    assign rd_pending_d = mem_rea;
    assign rd_owner_d   = prog_gnt;

    assign core_rvalid = rd_pending_q & ~rd_owner_q;
    assign prog_rvalid = rd_pending_q & rd_owner_q;
    assign core_rdata  = core_rvalid ? mem_dout : 32'h0;
    assign prog_rdata  = prog_rvalid ? mem_dout : 32'h0;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= ARB;
            timer_q      <= '0;
            lock_err_q   <= 1'b0;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            lock_err_q   <= lock_err_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] stall_cnt_q, prog_cnt_q, core_cnt_q;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            stall_cnt_q <= '0;
            prog_cnt_q  <= '0;
            core_cnt_q  <= '0;
        end else begin
            if (mem_hold && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (prog_gnt && (prog_cnt_q != '1))  prog_cnt_q  <= prog_cnt_q + 32'd1;
            if (core_gnt && (core_cnt_q != '1))  core_cnt_q  <= core_cnt_q + 32'd1;
        end
    end

    assign perf_core_stall = stall_cnt_q;
    assign perf_prog_gnt   = prog_cnt_q;
    assign perf_core_gnt   = core_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        Rst;
    logic        core_req, core_we, prog_req, prog_we, prog_lock;
    logic [3:0]  core_be, prog_be;
    logic [31:0] core_addr, prog_addr, core_wdata, prog_wdata, mem_dout;

    // Instance a: default LOCK_MAX; instance b: LOCK_MAX=4. Both share stimulus.
    logic        a_core_gnt, a_core_rvalid, a_prog_gnt, a_prog_rvalid;
    logic [31:0] a_core_rdata, a_prog_rdata, a_mem_addr, a_mem_din;
    logic [3:0]  a_mem_en;
    logic        a_mem_wea, a_mem_rea, a_mem_hold, a_lock_err;
    logic        b_core_gnt, b_core_rvalid, b_prog_gnt, b_prog_rvalid;
    logic [31:0] b_core_rdata, b_prog_rdata, b_mem_addr, b_mem_din;
    logic [3:0]  b_mem_en;
    logic        b_mem_wea, b_mem_rea, b_mem_hold, b_lock_err;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] a_perf_core_stall, a_perf_prog_gnt, a_perf_core_gnt;
    logic [31:0] b_perf_core_stall, b_perf_prog_gnt, b_perf_core_gnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .LOCK_MAX(256), .PRIO1_RESET(1'b1)) u_a (
        .clk(clk), .Rst(Rst),
        .core_req(core_req), .core_we(core_we), .core_be(core_be), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(a_core_gnt), .core_rvalid(a_core_rvalid),
        .core_rdata(a_core_rdata),
        .prog_req(prog_req), .prog_we(prog_we), .prog_be(prog_be), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .prog_lock(prog_lock), .prog_gnt(a_prog_gnt),
        .prog_rvalid(a_prog_rvalid), .prog_rdata(a_prog_rdata),
        .mem_en(a_mem_en), .mem_wea(a_mem_wea), .mem_rea(a_mem_rea), .mem_addr(a_mem_addr),
        .mem_din(a_mem_din), .mem_dout(mem_dout), .mem_hold(a_mem_hold), .lock_err(a_lock_err)
`ifdef ARB_PERF_CNT_EN
        , .perf_core_stall(a_perf_core_stall), .perf_prog_gnt(a_perf_prog_gnt),
        .perf_core_gnt(a_perf_core_gnt)
`endif
    );

    mem_port_arbiter #(.AW(32), .LOCK_MAX(4), .PRIO1_RESET(1'b1)) u_b (
        .clk(clk), .Rst(Rst),
        .core_req(core_req), .core_we(core_we), .core_be(core_be), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(b_core_gnt), .core_rvalid(b_core_rvalid),
        .core_rdata(b_core_rdata),
        .prog_req(prog_req), .prog_we(prog_we), .prog_be(prog_be), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .prog_lock(prog_lock), .prog_gnt(b_prog_gnt),
        .prog_rvalid(b_prog_rvalid), .prog_rdata(b_prog_rdata),
        .mem_en(b_mem_en), .mem_wea(b_mem_wea), .mem_rea(b_mem_rea), .mem_addr(b_mem_addr),
        .mem_din(b_mem_din), .mem_dout(mem_dout), .mem_hold(b_mem_hold), .lock_err(b_lock_err)
`ifdef ARB_PERF_CNT_EN
        , .perf_core_stall(b_perf_core_stall), .perf_prog_gnt(b_perf_prog_gnt),
        .perf_core_gnt(b_perf_core_gnt)
`endif
    );

    task automatic idle();
        core_req = 0; core_we = 0; core_be = 4'h0; core_addr = 0; core_wdata = 0;
        prog_req = 0; prog_we = 0; prog_be = 4'h0; prog_addr = 0; prog_wdata = 0;
        prog_lock = 0; mem_dout = 0;
    endtask

    task automatic reset_dut();
        idle();
        Rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        Rst = 1'b1;
        core_req = 1; prog_req = 1; core_be = 4'hF; prog_be = 4'hF;
        #1;
        checks++; if (a_core_gnt !== 1'b0 || a_prog_gnt !== 1'b0) begin failures++;
            $display("FAIL reset_gnt got=%b%b exp=00", a_core_gnt, a_prog_gnt); end
        checks++; if (a_mem_en !== 4'h0 || a_mem_wea !== 1'b0 || a_mem_rea !== 1'b0 || a_mem_addr !== 32'h0) begin failures++;
            $display("FAIL reset_mem got en=%h wea=%b rea=%b addr=%h exp all 0", a_mem_en, a_mem_wea, a_mem_rea, a_mem_addr); end
        checks++; if (a_mem_hold !== 1'b0 || a_lock_err !== 1'b0 || a_core_rvalid !== 1'b0 || a_prog_rvalid !== 1'b0) begin failures++;
            $display("FAIL reset_flags got hold=%b err=%b crv=%b prv=%b exp 0", a_mem_hold, a_lock_err, a_core_rvalid, a_prog_rvalid); end
        reset_dut();
    endtask

    task automatic test_core_read();
        reset_dut();
        @(negedge clk);
        core_req = 1; core_we = 0; core_be = 4'hF; core_addr = 32'h10;
        #1;
        checks++; if (a_core_gnt !== 1'b1 || a_prog_gnt !== 1'b0) begin failures++;
            $display("FAIL rd_gnt got core=%b prog=%b exp core=1 prog=0", a_core_gnt, a_prog_gnt); end
        checks++; if (a_mem_en !== 4'hF || a_mem_rea !== 1'b1 || a_mem_wea !== 1'b0 || a_mem_addr !== 32'h10) begin failures++;
            $display("FAIL rd_mem got en=%h rea=%b wea=%b addr=%h exp en=f rea=1 wea=0 addr=10", a_mem_en, a_mem_rea, a_mem_wea, a_mem_addr); end
        checks++; if (a_mem_hold !== 1'b0) begin failures++;
            $display("FAIL rd_hold got=%b exp=0", a_mem_hold); end
        @(negedge clk);
        idle(); mem_dout = 32'hDEADBEEF;
        #1;
        checks++; if (a_core_rvalid !== 1'b1 || a_core_rdata !== 32'hDEADBEEF) begin failures++;
            $display("FAIL rd_return got rvalid=%b rdata=%h exp rvalid=1 rdata=deadbeef", a_core_rvalid, a_core_rdata); end
        checks++; if (a_prog_rvalid !== 1'b0 || a_prog_rdata !== 32'h0) begin failures++;
            $display("FAIL rd_nonowner got rvalid=%b rdata=%h exp 0", a_prog_rvalid, a_prog_rdata); end
        @(negedge clk);
        idle(); mem_dout = 32'h12345678;
        #1;
        checks++; if (a_core_rvalid !== 1'b0 || a_core_rdata !== 32'h0) begin failures++;
            $display("FAIL rd_single got rvalid=%b rdata=%h exp 0", a_core_rvalid, a_core_rdata); end
        // Write with no byte enables is still granted.
        @(negedge clk);
        idle(); core_req = 1; core_we = 1; core_be = 4'h0; core_addr = 32'h20; core_wdata = 32'h55;
        #1;
        checks++; if (a_core_gnt !== 1'b1 || a_mem_en !== 4'h0 || a_mem_wea !== 1'b1 || a_mem_rea !== 1'b0 || a_mem_din !== 32'h55) begin failures++;
            $display("FAIL be0_write got gnt=%b en=%h wea=%b rea=%b din=%h exp gnt=1 en=0 wea=1 rea=0 din=55",
                     a_core_gnt, a_mem_en, a_mem_wea, a_mem_rea, a_mem_din); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_round_robin();
        logic exp_p;
        reset_dut();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            core_req = 1; core_we = 1; core_be = 4'hF; core_addr = 32'h200; core_wdata = 32'h22222222;
            prog_req = 1; prog_we = 1; prog_be = 4'h3; prog_addr = 32'h100; prog_wdata = 32'h11111111;
            exp_p = (c % 2 == 0);
            #1;
            checks++; if (a_prog_gnt !== exp_p || a_core_gnt !== ~exp_p) begin failures++;
                $display("FAIL rr_gnt c%0d got prog=%b core=%b exp prog=%b core=%b", c, a_prog_gnt, a_core_gnt, exp_p, ~exp_p); end
            checks++; if (a_mem_hold !== exp_p) begin failures++;
                $display("FAIL rr_hold c%0d got=%b exp=%b", c, a_mem_hold, exp_p); end
            checks++; if (a_mem_addr !== (exp_p ? 32'h100 : 32'h200) || a_mem_din !== (exp_p ? 32'h11111111 : 32'h22222222)
                          || a_mem_en !== (exp_p ? 4'h3 : 4'hF)) begin failures++;
                $display("FAIL rr_mux c%0d got addr=%h din=%h en=%h", c, a_mem_addr, a_mem_din, a_mem_en); end
        end
        @(negedge clk);
        idle();
        #1;
`ifdef ARB_PERF_CNT_EN
        checks++; if (a_perf_core_stall !== 32'd2 || a_perf_prog_gnt !== 32'd2 || a_perf_core_gnt !== 32'd2) begin failures++;
            $display("FAIL perf_cnt got stall=%0d prog=%0d core=%0d exp 2 2 2", a_perf_core_stall, a_perf_prog_gnt, a_perf_core_gnt); end
`endif
        checks++; if (a_core_gnt !== 1'b0 || a_prog_gnt !== 1'b0 || a_mem_en !== 4'h0) begin failures++;
            $display("FAIL rr_idle got core=%b prog=%b en=%h exp 0", a_core_gnt, a_prog_gnt, a_mem_en); end
    endtask

    task automatic test_lock_burst();
        reset_dut();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            core_req = 1; core_we = 1; core_be = 4'hF; core_addr = 32'h300; core_wdata = 32'hC0;
            prog_req = 1; prog_we = 1; prog_be = 4'hF; prog_addr = 32'h400 + 32'(4 * c); prog_wdata = 32'(c);
            prog_lock = (c < 7);
            #1;
            checks++; if (a_prog_gnt !== 1'b1 || a_core_gnt !== 1'b0 || a_mem_hold !== 1'b1) begin failures++;
                $display("FAIL burst c%0d got prog=%b core=%b hold=%b exp 1 0 1", c, a_prog_gnt, a_core_gnt, a_mem_hold); end
            checks++; if (a_mem_addr !== 32'h400 + 32'(4 * c)) begin failures++;
                $display("FAIL burst_addr c%0d got=%h exp=%h", c, a_mem_addr, 32'h400 + 32'(4 * c)); end
        end
        @(negedge clk);
        prog_lock = 0; prog_addr = 32'h500;
        #1;
        checks++; if (a_core_gnt !== 1'b1 || a_prog_gnt !== 1'b0 || a_mem_hold !== 1'b0 || a_mem_addr !== 32'h300) begin failures++;
            $display("FAIL burst_release got core=%b prog=%b hold=%b addr=%h exp 1 0 0 300", a_core_gnt, a_prog_gnt, a_mem_hold, a_mem_addr); end
        checks++; if (a_lock_err !== 1'b0) begin failures++;
            $display("FAIL burst_err got=%b exp=0", a_lock_err); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_lock_timeout();
        logic exp_p, exp_e;
        reset_dut();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            core_req = 1; core_we = 1; core_be = 4'hF; core_addr = 32'h600;
            prog_req = 1; prog_we = 1; prog_be = 4'hF; prog_addr = 32'h700; prog_lock = 1;
            exp_p = (c < 5) || (c % 2 == 0);
            exp_e = (c >= 5);
            #1;
            checks++; if (b_prog_gnt !== exp_p || b_core_gnt !== ~exp_p) begin failures++;
                $display("FAIL timeout_gnt c%0d got prog=%b core=%b exp prog=%b core=%b", c, b_prog_gnt, b_core_gnt, exp_p, ~exp_p); end
            checks++; if (b_lock_err !== exp_e) begin failures++;
                $display("FAIL timeout_err c%0d got=%b exp=%b", c, b_lock_err, exp_e); end
        end
        @(negedge clk);
        idle();
        #1;
        checks++; if (b_lock_err !== 1'b1) begin failures++;
            $display("FAIL err_sticky got=%b exp=1", b_lock_err); end
        @(negedge clk);
        #1;
        checks++; if (b_lock_err !== 1'b0) begin failures++;
            $display("FAIL err_clear got=%b exp=0", b_lock_err); end
    endtask

    task automatic test_reset_mid_read();
        reset_dut();
        @(negedge clk);
        prog_req = 1; prog_we = 0; prog_be = 4'hF; prog_addr = 32'h40; mem_dout = 32'hA5A5A5A5;
        #1;
        checks++; if (a_prog_gnt !== 1'b1 || a_mem_rea !== 1'b1 || a_mem_addr !== 32'h40) begin failures++;
            $display("FAIL prd_gnt got gnt=%b rea=%b addr=%h exp 1 1 40", a_prog_gnt, a_mem_rea, a_mem_addr); end
        @(posedge clk);
        #2;
        Rst = 1'b1;
        #1;
        checks++; if (a_prog_rvalid !== 1'b0 || a_prog_rdata !== 32'h0) begin failures++;
            $display("FAIL rst_rvalid got rvalid=%b rdata=%h exp 0", a_prog_rvalid, a_prog_rdata); end
        checks++; if (a_prog_gnt !== 1'b0 || a_mem_en !== 4'h0 || a_mem_rea !== 1'b0 || a_mem_addr !== 32'h0) begin failures++;
            $display("FAIL rst_outputs got gnt=%b en=%h rea=%b addr=%h exp 0", a_prog_gnt, a_mem_en, a_mem_rea, a_mem_addr); end
        @(negedge clk);
        idle();
        Rst = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (a_prog_rvalid !== 1'b0) begin failures++;
            $display("FAIL rst_after got rvalid=%b exp=0", a_prog_rvalid); end
    endtask

    initial begin
        idle();
        Rst = 1'b1;
        test_reset();
        test_core_read();
        test_round_robin();
        test_lock_burst();
        test_lock_timeout();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
